// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared constants, FSM encoding and affine helpers for the byte-serial (Inv)SubBytes engine.
// The forward direction is enabled with the AES_SBOX_FWD_EN macro in the top module.
package inv_sub_bytes_seq_pkg;

    localparam int unsigned NBYTES    = 16;
    localparam int unsigned EXP_STEPS = 8;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned STATE_W   = NBYTES * BYTE_W;
    localparam int unsigned IDX_W     = $clog2(NBYTES);
    localparam int unsigned STEP_W    = $clog2(EXP_STEPS);

    localparam logic [8:0]        GF_POLY   = 9'h11B;
    localparam logic [BYTE_W-1:0] AFF_C     = 8'h63;
    localparam logic [BYTE_W-1:0] INV_AFF_D = 8'h05;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Forward affine: y_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i, written as left rotations.
    function automatic logic [BYTE_W-1:0] aff(input logic [BYTE_W-1:0] b);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ AFF_C;
    endfunction

    // Inverse affine: y_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ d_i.
    function automatic logic [BYTE_W-1:0] inv_aff(input logic [BYTE_W-1:0] b);
        return {b[1:0], b[7:2]}
             ^ {b[4:0], b[7:5]}
             ^ {b[6:0], b[7]}
             ^ INV_AFF_D;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_gf256_sqmul.sv
// Combinational GF(2^8) square-and-multiply step: r^2 * x, or r^2 alone when square_only is set.
module gf256_sqmul
    import inv_sub_bytes_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] r,
    input  logic [BYTE_W-1:0] x,
    input  logic              square_only,
    output logic [BYTE_W-1:0] y_c
);

    // Shift-and-add multiply with reduction by GF_POLY on every doubling.
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] p;
        logic [BYTE_W-1:0] aa;
        logic [BYTE_W-1:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? GF_POLY[BYTE_W-1:0] : BYTE_W'(0));
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    logic [BYTE_W-1:0] r_sq_c;

    always_comb begin
        r_sq_c = gf_mul(r, r);
        y_c    = square_only ? r_sq_c : gf_mul(r_sq_c, x);
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Byte-serial InvSubBytes over a 128-bit state; 8 cycles per byte via x^254 square-and-multiply.
// Define AES_SBOX_FWD_EN to add the dir port and forward SubBytes support.
module inv_sub_bytes_seq
    import inv_sub_bytes_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
`ifdef AES_SBOX_FWD_EN
    ,
    input  logic               dir
`endif
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(EXP_STEPS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NBYTES - 1);

    fsm_state_t         fsm_q, fsm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [BYTE_W-1:0]  x_q, x_d;
    logic [BYTE_W-1:0]  r_q, r_d;
    logic [STATE_W-1:0] in_buf_q, in_buf_d;
    logic [STATE_W-1:0] out_state_d;
    logic               in_ready_d, out_valid_d, busy_d;
`ifdef AES_SBOX_FWD_EN
    logic               dir_q, dir_d;
`endif

    logic [BYTE_W-1:0]  cur_byte_c;
    logic [BYTE_W-1:0]  load_byte_c;
    logic [BYTE_W-1:0]  res_byte_c;
    logic [BYTE_W-1:0]  sq_c;
    logic               square_only_c;

    assign square_only_c = (step_q == LAST_STEP);
    // The input buffer shifts left one byte per element, so byte k is always on top.
    assign cur_byte_c    = in_buf_q[STATE_W-1 -: BYTE_W];

`ifdef AES_SBOX_FWD_EN
    assign load_byte_c = dir_q ? cur_byte_c : inv_aff(cur_byte_c);
    assign res_byte_c  = dir_q ? aff(sq_c) : sq_c;
`else
    assign load_byte_c = inv_aff(cur_byte_c);
    assign res_byte_c  = sq_c;
`endif

    gf256_sqmul u_sqmul (
        .r           (r_q),
        .x           (x_q),
        .square_only (square_only_c),
        .y_c         (sq_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            idx_q     <= '0;
            step_q    <= '0;
            x_q       <= '0;
            r_q       <= '0;
            in_buf_q  <= '0;
            out_state <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_SBOX_FWD_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            fsm_q     <= fsm_d;
            idx_q     <= idx_d;
            step_q    <= step_d;
            x_q       <= x_d;
            r_q       <= r_d;
            in_buf_q  <= in_buf_d;
            out_state <= out_state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
`ifdef AES_SBOX_FWD_EN
            dir_q     <= dir_d;
`endif
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        idx_d       = idx_q;
        step_d      = step_q;
        x_d         = x_q;
        r_d         = r_q;
        in_buf_d    = in_buf_q;
        out_state_d = out_state;
`ifdef AES_SBOX_FWD_EN
        dir_d       = dir_q;
`endif

        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    in_buf_d = in_state;
                    idx_d    = '0;
                    step_d   = '0;
                    fsm_d    = RUN;
`ifdef AES_SBOX_FWD_EN
                    dir_d    = dir;
`endif
                end
            end
            RUN: begin
                step_d = step_q + STEP_W'(1);
                if (step_q == '0) begin
                    x_d = load_byte_c;
                    r_d = load_byte_c;
                end else if (square_only_c) begin
                    // Result bytes enter at the bottom so byte 0 ends up on top after 16 shifts.
                    out_state_d = {out_state[STATE_W-BYTE_W-1:0], res_byte_c};
                    in_buf_d    = {in_buf_q[STATE_W-BYTE_W-1:0], BYTE_W'(0)};
                    idx_d       = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        fsm_d = DONE;
                    end
                end else begin
                    r_d = sq_c;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Randomized self-checking bench for inv_sub_bytes_seq against an S-box model built from field arithmetic.
// Build with AES_SBOX_FWD_EN to also exercise the forward direction.
module tb_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] out_state;
`ifdef AES_SBOX_FWD_EN
    logic         dir = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    inv_sub_bytes_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
`ifdef AES_SBOX_FWD_EN
        ,
        .dir       (dir)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference field multiply with plain integer arithmetic.
    function automatic int m_mul(input int a, input int b);
        int p;
        int aa;
        int bb;
        p = 0;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if ((bb & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 256) != 0) aa = aa ^ 283;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    // Forward S-box from brute-force inverse plus affine map; inverse table is its permutation inverse.
    task automatic build_tables();
        int inv;
        int s;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) begin
                if (m_mul(x, y) == 1) inv = y;
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x] = 8'(s);
            isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] exp_state(input logic [127:0] st, input logic d);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = st[127 - 8*k -: 8];
            r[127 - 8*k -: 8] = d ? sbox[b] : isbox[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction; optional DONE backpressure (hold) and ignored in_valid pulses during RUN.
    task automatic do_txn(input logic [127:0] st, input logic d, input int hold, input bit pulse,
                          output logic [127:0] res, output int lat);
        int t0;
        bit got;
        logic [127:0] snap;
        res = 'x;
        lat = -1;
        got = 0;
        @(negedge clk);
        for (int i = 0; i < 300 && in_ready !== 1'b1; i++) @(negedge clk);
        if (in_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            return;
        end
        in_state = st;
        in_valid = 1'b1;
`ifdef AES_SBOX_FWD_EN
        dir = d;
`endif
        @(negedge clk);
        t0 = cyc;
        in_valid = 1'b0;
`ifdef AES_SBOX_FWD_EN
        dir = ~d;
`endif
        for (int i = 0; i < 300; i++) begin
            if (out_valid === 1'b1) begin
                got = 1;
                break;
            end
            if (pulse) begin
                in_valid = 1'($urandom % 2);
                in_state = rand_state();
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: out_valid=%b required 1 within 300 cycles", out_valid);
            return;
        end
        lat = cyc - t0;
        snap = out_state;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_state !== snap || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL hold_stable c%0d: valid/ready/busy=%b%b%b state=%h required 101 %h",
                         i, out_valid, in_ready, busy, out_state, snap);
            end
        end
        res = out_state;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_handshake: valid/ready/busy=%b%b%b required 010", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_state !== 128'h0) begin
            n_err++;
            $display("FAIL reset_values: ready/valid/busy=%b%b%b state=%h required 000 0",
                     in_ready, out_valid, busy, out_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [127:0] res;
        int lat;
        do_txn({16{8'h63}}, 1'b0, 0, 0, res, lat);
        n_cmp++;
        if (res !== 128'h0) begin n_err++; $display("FAIL all_63: got %h required 0", res); end
        n_cmp++;
        if (lat !== 128) begin n_err++; $display("FAIL latency: got %0d required 128", lat); end
        do_txn(128'h0, 1'b0, 0, 0, res, lat);
        n_cmp++;
        if (res !== {16{8'h52}}) begin n_err++; $display("FAIL all_00: got %h required %h", res, {16{8'h52}}); end
        do_txn({8'h7C, {15{8'h63}}}, 1'b0, 0, 0, res, lat);
        n_cmp++;
        if (res !== {8'h01, 120'h0}) begin n_err++; $display("FAIL byte_order: got %h required %h", res, {8'h01, 120'h0}); end
    endtask

    task automatic test_exhaustive();
        logic [127:0] st;
        logic [127:0] res;
        logic [7:0]   got [256];
        int lat;
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < 16; k++) st[127 - 8*k -: 8] = 8'(16*t + k);
            do_txn(st, 1'b0, 0, 0, res, lat);
            for (int k = 0; k < 16; k++) begin
                got[16*t + k] = res[127 - 8*k -: 8];
                n_cmp++;
                if (got[16*t + k] !== isbox[16*t + k]) begin
                    n_err++;
                    $display("FAIL exhaustive in=%02h: got %02h required %02h", 16*t + k, got[16*t + k], isbox[16*t + k]);
                end
            end
        end
        n_cmp++;
        if (got[8'hED] !== 8'h53) begin n_err++; $display("FAIL fips_ED: got %02h required 53", got[8'hED]); end
        n_cmp++;
        if (got[8'h16] !== 8'hFF) begin n_err++; $display("FAIL fips_16: got %02h required ff", got[8'h16]); end
    endtask

    task automatic test_random();
        logic [127:0] st;
        logic [127:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            st = rand_state();
            do_txn(st, 1'b0, int'($urandom_range(0, 3)), 0, res, lat);
            n_cmp++;
            if (res !== exp_state(st, 1'b0)) begin
                n_err++;
                $display("FAIL random_%0d: got %h required %h", i, res, exp_state(st, 1'b0));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] st;
        logic [127:0] res;
        int lat;
        st = rand_state();
        do_txn(st, 1'b0, 20, 1, res, lat);
        n_cmp++;
        if (res !== exp_state(st, 1'b0)) begin
            n_err++;
            $display("FAIL backpressure_result: got %h required %h", res, exp_state(st, 1'b0));
        end
        n_cmp++;
        if (lat !== 128) begin n_err++; $display("FAIL backpressure_latency: got %0d required 128", lat); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] st;
        logic [127:0] res;
        bit seen;
        int lat;
        seen = 0;
        @(negedge clk);
        in_state = rand_state();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_state !== 128'h0) begin
            n_err++;
            $display("FAIL midrun_reset: ready/valid/busy=%b%b%b state=%h required 000 0",
                     in_ready, out_valid, busy, out_state);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (140) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_discard: seen_valid=%0d busy=%b ready=%b required 0 0 1", seen, busy, in_ready);
        end
        st = rand_state();
        do_txn(st, 1'b0, 0, 0, res, lat);
        n_cmp++;
        if (res !== exp_state(st, 1'b0)) begin
            n_err++;
            $display("FAIL after_reset: got %h required %h", res, exp_state(st, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] s [2];
        int t_acc [2];
        int acc;
        int outs;
        s[0] = rand_state();
        s[1] = rand_state();
        acc = 0;
        outs = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 600 && outs < 2; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (out_state !== exp_state(s[outs], 1'b0)) begin
                    n_err++;
                    $display("FAIL b2b_result_%0d: got %h required %h", outs, out_state, exp_state(s[outs], 1'b0));
                end
                outs++;
            end
            if (acc < 2) begin
                in_valid = 1'b1;
                in_state = s[acc];
                if (in_ready === 1'b1) begin
                    t_acc[acc] = cyc + 1;
                    acc++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (outs != 2 || acc != 2 || t_acc[1] - t_acc[0] != 130) begin
            n_err++;
            $display("FAIL b2b_throughput: outs=%0d accepts=%0d spacing=%0d required 2 2 130",
                     outs, acc, (acc == 2) ? t_acc[1] - t_acc[0] : -1);
        end
    endtask

`ifdef AES_SBOX_FWD_EN
    task automatic test_forward();
        logic [127:0] st;
        logic [127:0] res;
        logic [127:0] ex;
        int lat;
        st = rand_state();
        st[127:104] = 24'h005301;
        ex = exp_state(st, 1'b1);
        do_txn(st, 1'b1, 0, 0, res, lat);
        n_cmp++;
        if (res[127:104] !== 24'h63ED7C) begin
            n_err++;
            $display("FAIL fwd_known: got %h required 63ed7c", res[127:104]);
        end
        n_cmp++;
        if (res !== ex) begin n_err++; $display("FAIL fwd_state: got %h required %h", res, ex); end
        n_cmp++;
        if (lat !== 128) begin n_err++; $display("FAIL fwd_latency: got %0d required 128", lat); end
    endtask
`endif

    initial begin
        build_tables();
        test_reset();
        test_directed();
        test_exhaustive();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef AES_SBOX_FWD_EN
        test_forward();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Byte-serial sequential engine that applies AES InvSubBytes to a full 128-bit state. Each byte goes through the inverse affine transform, then a GF(2^8) multiplicative inverse computed as x^254 by square-and-multiply. It is the decryption-side counterpart of the forward S-box inversion datapath and sits between InvShiftRows and AddRoundKey in the iterative decryption round. Area is traded for latency: one shared square-multiply datapath serves all 16 bytes.

## Interface
Parameters:
- none (all constants live in the shared package)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input state valid
- in_ready  out  1  engine idle; a state can be accepted
- in_state  in  128  input state; byte k = bits [127-8k -: 8]; byte 0 is processed first
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts the result
- out_state  out  128  result, same byte order as in_state
- busy  out  1  high in RUN and DONE
- dir  in  1  0 = inverse, 1 = forward; exists only with AES_SBOX_FWD_EN

## Operation
- Field: GF(2^8) with reduction polynomial 0x11B.
- Inverse affine: y_i = b_(i+2)%8 ^ b_(i+5)%8 ^ b_(i+7)%8 ^ d_i, with d = 0x05.
- Inversion: x^254 with exponent 11111110b, processed MSB-first.
  - Load: r = x.
  - Six steps of r = r²·x.
  - One final step: r = r².
  - 0 maps to 0 with no special case.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_state, byte index k=0, step=0, go to RUN.
  - RUN, 8 cycles per byte:
    - step 0: x = InvAff(byte k); r = x.
    - steps 1–6: r = r²·x.
    - step 7: write r² into result byte k; k++.
    - After byte 15 step 7, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- out_state and out_valid stay stable in DONE regardless of out_ready. in_valid is ignored outside IDLE.
- Reset values: in_ready=0 while rst_n is low and 1 from the first cycle after release; out_valid=0; busy=0; out_state=0; FSM in IDLE; k=0; step=0.
- Reset mid-operation clears all state asynchronously. The partial result is discarded and never presented.

## Timing
- Input handshake completes at edge E0 (in_valid && in_ready).
- Byte k occupies edges E0+8k+1 … E0+8k+8.
- out_valid rises at edge E0+128, so latency is exactly 128 cycles.
- Output handshake completes at edge E1 (out_valid && out_ready). in_ready is 1 after E1; the earliest next accept is E1+1.
- No overlap between consecutive states.
- out_ready held high through DONE gives a 1-cycle DONE and a throughput of one state per 130 cycles.
- The square-multiply datapath is purely combinational within one cycle, registered into r.

## Configuration
- AES_SBOX_FWD_EN defined:
  - The dir port exists.
  - dir is sampled at the input handshake.
  - dir=1 gives forward SubBytes: step 0 loads x = byte unchanged; step 7 writes Aff(r²), where Aff: y_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i with c = 0x63.
  - Latency is unchanged.
- AES_SBOX_FWD_EN undefined: the dir port and the forward affine logic are absent; inverse only.

## Structure
- Shared package holds:
  - GF_POLY = 9'h11B, AFF_C = 8'h63, INV_AFF_D = 8'h05
  - NBYTES = 16, EXP_STEPS = 8
  - FSM state enum {IDLE, RUN, DONE}
  - affine and inverse-affine functions
- One sub-module, gf256_sqmul (combinational):
  - inputs r, x, and a select square_only
  - output r²·x, or r² when square_only is set

## Test plan
- All bytes 0x63 → all bytes 0x00; out_valid rises exactly 128 cycles after acceptance.
- All 0x00 → all 0x52. Byte 0 = 0x7C with bytes 1–15 = 0x63 → byte 0 = 0x01, rest 0x00 (checks byte order).
- Exhaustive: 16 transactions covering inputs 0x00–0xFF compared against the FIPS-197 inverse S-box table (e.g. 0xED→0x53, 0x16→0xFF).
- Backpressure:
  - hold out_ready=0 for 20 cycles in DONE; out_state and out_valid must stay stable and in_ready stay 0.
  - in_valid pulses during RUN are ignored.
- Deassert rst_n at cycle 50 of RUN:
  - out_valid never rises and all outputs return to their reset values.
  - the next transaction after release produces the correct result.
- With AES_SBOX_FWD_EN and dir=1: 0x00→0x63, 0x53→0xED, 0x01→0x7C, with the same 128-cycle latency.
